seg7_scan: RTL

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_font.sv | 18 +
 rtl/seg7_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants for the seven-segment scanner.
// Segment encoding is active-low: bit7 = dot, bits6..0 = g..a.
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] SEG_DP_MASK = 8'h7F;

   // Index 0 is the rightmost entry; glyphs 0-9, A b C d E F
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg7_font.sv
// seg7_font: combinational nibble-to-glyph decode with optional decimal point.
module seg7_font
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_dot,
   output logic [7:0] o_seg_c
);

   // Look up the hex glyph and pull the dot segment low on request
   always_comb begin
      o_seg_c = SEG_HEX[i_nib];
      if (i_dot) begin
         o_seg_c = o_seg_c & SEG_DP_MASK;
      end
   end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment scanner with double-buffered display
// data, per-slot ghost blanking and frame-aligned commit of new values.
// Optional build macro SEG7_LZS_EN enables leading-zero suppression.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned NDIG = 4,
   parameter int unsigned DIV  = 50000,
   parameter int unsigned GAP  = 2
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic [4*NDIG-1:0] DIN,
   input  logic [NDIG-1:0]   DOT,
   input  logic [NDIG-1:0]   BLANK,
   input  logic              LOAD,
   output logic [7:0]        nHEX,
   output logic [NDIG-1:0]   nDIG,
   output logic              FRAME,
   output logic              PEND
);

   localparam int unsigned CW = $clog2(DIV);
   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [4*NDIG-1:0] r_pend_din;
   logic [NDIG-1:0]   r_pend_dot;
   logic [NDIG-1:0]   r_pend_blank;
   logic [4*NDIG-1:0] r_act_din;
   logic [NDIG-1:0]   r_act_dot;
   logic [NDIG-1:0]   r_act_blank;
   logic              r_pend;
   logic              r_frame;
   logic [7:0]        r_nhex;
   logic [NDIG-1:0]   r_ndig;

   logic              w_tick;
   logic              w_wrap;
   logic              w_frame_next;
   logic              w_gap;
   logic [3:0]        w_nib;
   logic              w_dot;
   logic              w_blank;
   logic [NDIG-1:0]   w_lzs;
   logic [7:0]        w_glyph;

   // Slot timing: tick at end of each slot, wrap at end of the last slot
   always_comb begin
      w_tick       = (r_cnt == CW'(DIV - 1));
      w_wrap       = w_tick && (r_idx == IW'(NDIG - 1));
      w_frame_next = (r_cnt == CW'(DIV - 2)) && (r_idx == IW'(NDIG - 1));
      w_gap        = (r_cnt < CW'(GAP));
      w_nib        = r_act_din[4*r_idx +: 4];
      w_dot        = r_act_dot[r_idx];
      w_blank      = r_act_blank[r_idx] | w_lzs[r_idx];
   end

   // Leading-zero mask: digit k>0 blanks when it and all higher nibbles are zero
   always_comb begin : lzs_mask
      logic v_hi_zero;
      v_hi_zero = 1'b1;
      w_lzs     = '0;
`ifdef SEG7_LZS_EN
      for (int k = NDIG - 1; k > 0; k--) begin
         v_hi_zero = v_hi_zero && (r_act_din[4*k +: 4] == 4'h0);
         w_lzs[k]  = v_hi_zero && !r_act_dot[k];
      end
`else
      v_hi_zero = 1'b0;
`endif
   end

   seg7_font u_font (
      .i_nib   (w_nib),
      .i_dot   (w_dot),
      .o_seg_c (w_glyph)
   );

   // Scan counters, buffer management and registered display outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_din   <= '0;
         r_pend_dot   <= '0;
         r_pend_blank <= '0;
         r_act_din    <= '0;
         r_act_dot    <= '0;
         r_act_blank  <= '0;
         r_pend       <= 1'b0;
         r_frame      <= 1'b0;
         r_nhex       <= SEG_BLANK;
         r_ndig       <= '1;
      end else begin
         r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
         r_frame <= w_frame_next;

         if (w_wrap) begin
            r_idx <= '0;
         end else if (w_tick) begin
            r_idx <= r_idx + IW'(1);
         end

         // A load on the wrap cycle bypasses pending so it is never delayed a frame
         if (w_wrap && LOAD) begin
            r_act_din   <= DIN;
            r_act_dot   <= DOT;
            r_act_blank <= BLANK;
            r_pend      <= 1'b0;
         end else if (w_wrap && r_pend) begin
            r_act_din   <= r_pend_din;
            r_act_dot   <= r_pend_dot;
            r_act_blank <= r_pend_blank;
            r_pend      <= 1'b0;
         end else if (LOAD) begin
            r_pend_din   <= DIN;
            r_pend_dot   <= DOT;
            r_pend_blank <= BLANK;
            r_pend       <= 1'b1;
         end

         // Ghost suppression keeps all digits off at the start of each slot
         if (w_gap) begin
            r_ndig <= '1;
            r_nhex <= SEG_BLANK;
         end else begin
            r_ndig <= ~(NDIG'(1) << r_idx);
            r_nhex <= w_blank ? SEG_BLANK : w_glyph;
         end
      end
   end

   assign nHEX  = r_nhex;
   assign nDIG  = r_ndig;
   assign FRAME = r_frame;
   assign PEND  = r_pend;

endmodule
